// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: scheduler FSM states, frame geometry and the latch
// holdoff that every pattern generator driving the strip must agree on.
package ws2812_pkg;

  localparam int WS2812_BYTES_PER_LED = 3;

  // Cycles the data line must stay idle so the strip latches the frame.
  localparam int WS2812_HOLDOFF = 1200000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_LATCH
  } sched_state_e;

  // Counter width that stays at least one bit for degenerate sizes of 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_arbiter.sv
// Combinational one-hot round-robin arbiter; the search starts one past the
// previous winner and wraps, so every requester is served in turn.
module rr_arbiter
  import ws2812_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDX_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [NREQ-1:0]  grant_onehot,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand_idx;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_onehot = '0;
    winner       = '0;
    valid        = 1'b0;
    cand_idx     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_idx = IDX_W'((int'(last_winner) + off) % NREQ);
      if (!valid && req[cand_idx]) begin
        valid                  = 1'b1;
        winner                 = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Shares one WS2812 strip driver between several pattern sources: one full
// frame per grant (trigger, LEDS*3 bytes, latch holdoff), round-robin between frames.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int LEDS    = 32,
  parameter int NREQ    = 2,
  parameter int HOLDOFF = WS2812_HOLDOFF,
  localparam int LED_W  = clog2_min1(LEDS)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] src_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   src_advance,
  output logic [LED_W-1:0]  led_index,
  output logic [1:0]        rgb_index,
  output logic              frame_done,
  output logic              busy,
  output logic              drv_trigger,
  output logic [7:0]        drv_data,
  input  logic              drv_request
);

  localparam int IDX_W = clog2_min1(NREQ);
  localparam int HO_W  = clog2_min1(HOLDOFF);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF - 1);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LEDS - 1);
  localparam logic [1:0]       RGB_LAST = 2'(WS2812_BYTES_PER_LED - 1);

  sched_state_e     state, state_next;
  logic [IDX_W-1:0] last_winner;
  logic [HO_W-1:0]  holdoff_cnt;

  logic [NREQ-1:0]  arb_onehot;
  logic [IDX_W-1:0] arb_winner;
  logic             arb_valid;

  logic byte_take;
  logic last_byte;
  logic holdoff_zero;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arbiter (
    .req          (req),
    .last_winner  (last_winner),
    .grant_onehot (arb_onehot),
    .winner       (arb_winner),
    .valid        (arb_valid)
  );

  // Driver handshakes only count while streaming; stray ones elsewhere are dropped.
  assign byte_take    = (state == ST_STREAM) && drv_request;
  assign last_byte    = (led_index == LED_LAST) && (rgb_index == RGB_LAST);
  assign holdoff_zero = (holdoff_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (arb_valid) state_next = ST_START;
      ST_START:  state_next = ST_STREAM;
      ST_STREAM: if (byte_take && last_byte) state_next = ST_LATCH;
      ST_LATCH:  if (holdoff_zero) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    drv_trigger = (state == ST_START);
    busy        = (state != ST_IDLE);
    drv_data    = '0;
    src_advance = '0;
    if (state == ST_STREAM) begin
      for (int i = 0; i < NREQ; i++) begin
        drv_data = drv_data | (src_data[8*i +: 8] & {8{grant[i]}});
      end
      src_advance = grant & {NREQ{drv_request}};
    end
  end

  // Grant, byte position and holdoff bookkeeping for the frame in flight.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      last_winner <= IDX_W'(NREQ - 1);
      led_index   <= '0;
      rgb_index   <= '0;
      holdoff_cnt <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant       <= arb_onehot;
            last_winner <= arb_winner;
          end
        end
        ST_STREAM: begin
          if (byte_take) begin
            if (last_byte) begin
              grant       <= '0;
              led_index   <= '0;
              rgb_index   <= '0;
              holdoff_cnt <= HO_LOAD;
              frame_done  <= 1'b1;
            end else if (rgb_index == RGB_LAST) begin
              rgb_index <= '0;
              led_index <= led_index + LED_W'(1);
            end else begin
              rgb_index <= rgb_index + 2'd1;
            end
          end
        end
        ST_LATCH: begin
          if (!holdoff_zero) holdoff_cnt <= holdoff_cnt - HO_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench: LEDS=2, NREQ=2, HOLDOFF=4, driver requesting every third
// cycle, random source bytes and request patterns against a frame-level model.
module tb_ws2812_frame_scheduler;

  localparam int LEDS    = 2;
  localparam int NREQ    = 2;
  localparam int HOLDOFF = 4;
  localparam int NBYTES  = LEDS * 3;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] src_data;
  logic        drv_request;
  logic [1:0]  grant;
  logic [1:0]  src_advance;
  logic [0:0]  led_index;
  logic [1:0]  rgb_index;
  logic        frame_done;
  logic        busy;
  logic        drv_trigger;
  logic [7:0]  drv_data;

  ws2812_frame_scheduler #(
    .LEDS(LEDS),
    .NREQ(NREQ),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .req         (req),
    .src_data    (src_data),
    .grant       (grant),
    .src_advance (src_advance),
    .led_index   (led_index),
    .rgb_index   (rgb_index),
    .frame_done  (frame_done),
    .busy        (busy),
    .drv_trigger (drv_trigger),
    .drv_data    (drv_data),
    .drv_request (drv_request)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_bad  = 0;
  int cyc_no = 0;
  int last_w = NREQ - 1;

  logic [7:0] base [2];
  int         cnt  [2];

  logic [1:0] s_grant, s_adv, s_rgb;
  logic [0:0] s_led;
  logic       s_fd, s_busy, s_trig, s_req;
  logic [7:0] s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < 2; i++) src_data[8*i +: 8] = base[i] + 8'(cnt[i]);
  endtask

  task automatic new_pattern();
    for (int i = 0; i < 2; i++) begin
      base[i] = 8'($urandom);
      cnt[i]  = 0;
    end
    drive_src();
  endtask

  // One clock cycle: sample mid-cycle, then after the edge let each source
  // step past a consumed byte and schedule the driver's next request.
  task automatic cyc();
    cyc_no++;
    #4;
    s_grant = grant;
    s_adv   = src_advance;
    s_led   = led_index;
    s_rgb   = rgb_index;
    s_fd    = frame_done;
    s_busy  = busy;
    s_trig  = drv_trigger;
    s_data  = drv_data;
    s_req   = drv_request;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) if (s_adv[i]) cnt[i]++;
    drive_src();
    drv_request = ((cyc_no + 1) % 3 == 0);
  endtask

  function automatic int next_winner(input logic [1:0] r, input int last);
    int idx;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (last + off) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Follows one frame from its trigger through holdoff; returns the cycle the
  // next trigger is due if requests keep coming.
  task automatic run_frame(input int w, input int exp_trig, input bit release_req,
                           input bit drop0, input int abort_after, output int next_trig);
    int  bytes;
    int  advs;
    int  lat;
    int  first_req;
    int  last_req;
    bit  got;
    bytes     = 0;
    advs      = 0;
    next_trig = -1;
    got       = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      cyc();
      if (s_trig) got = 1'b1;
      else begin
        check("idle_busy", s_busy, 0);
        check("idle_grant", s_grant, 0);
        check("idle_adv", s_adv, 0);
        check("idle_data", s_data, 0);
      end
    end
    check("trigger_seen", got, 1);
    if (!got) return;
    check("trig_cycle", cyc_no, exp_trig);
    check("start_grant", s_grant, 1 << w);
    check("start_adv", s_adv, 0);
    check("start_data", s_data, 0);
    check("start_index", {s_led, s_rgb}, 0);
    if (release_req) req = 2'b00;

    first_req = ((exp_trig + 3) / 3) * 3;
    last_req  = first_req + 3 * (NBYTES - 1);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      cyc();
      if (s_fd) got = 1'b1;
      else begin
        check("stream_grant", s_grant, 1 << w);
        check("stream_trig", s_trig, 0);
        check("stream_adv", s_adv, s_req ? (1 << w) : 0);
        check("stream_data", s_data, 8'(base[w] + 8'(bytes)));
        if (s_req) begin
          check("led_index", s_led, bytes / 3);
          check("rgb_index", s_rgb, bytes % 3);
          bytes++;
          advs += int'(s_adv[w]);
          if (drop0 && bytes == 3) req[0] = 1'b0;
          if (abort_after != 0 && bytes == abort_after) return;
        end
      end
    end
    check("frame_done_seen", got, 1);
    check("frame_bytes", bytes, NBYTES);
    check("frame_advances", advs, NBYTES);
    check("done_cycle", cyc_no, last_req + 1);
    check("done_grant", s_grant, 0);
    check("done_busy", s_busy, 1);
    new_pattern();

    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc();
      if (!s_busy) got = 1'b1;
      else begin
        lat++;
        check("latch_done", s_fd, 0);
        check("latch_grant", s_grant, 0);
        check("latch_adv", s_adv, 0);
        check("latch_data", s_data, 0);
        check("latch_index", {s_led, s_rgb}, 0);
      end
    end
    check("latch_len", lat, HOLDOFF);
    next_trig = last_req + HOLDOFF + 2;
  endtask

  initial begin
    int w;
    int nt;
    rst_n       = 1'b0;
    req         = 2'b00;
    drv_request = 1'b0;
    base[0] = 8'h00;
    base[1] = 8'h00;
    cnt[0]  = 0;
    cnt[1]  = 0;
    drive_src();
    @(posedge CLK);
    #1;

    // Reset, then a quiet idle with nothing requested.
    repeat (3) begin
      cyc();
      check("reset_outputs", {s_grant, s_adv, s_led, s_rgb, s_fd, s_busy, s_trig, s_data}, 0);
    end
    rst_n = 1'b1;
    repeat (12) begin
      cyc();
      check("quiet_busy", s_busy, 0);
      check("quiet_grant", s_grant, 0);
    end

    // Single frame from source 0 starting at 0xA0.
    base[0] = 8'hA0;
    base[1] = 8'h5B;
    drive_src();
    req    = 2'b01;
    w      = next_winner(req, last_w);
    last_w = w;
    run_frame(w, cyc_no + 2, 1'b1, 1'b0, 0, nt);
    repeat (6) begin
      cyc();
      check("after_single_busy", s_busy, 0);
    end

    // Round-robin with both requests held, from a fresh reset.
    rst_n = 1'b0;
    cyc();
    rst_n  = 1'b1;
    last_w = NREQ - 1;
    new_pattern();
    req = 2'b11;
    nt  = cyc_no + 2;
    for (int f = 0; f < 4; f++) begin
      w      = next_winner(req, last_w);
      last_w = w;
      run_frame(w, nt, (f == 3), 1'b0, 0, nt);
    end

    // Requester 0 drops out after byte 2; the frame still completes.
    req    = 2'b01;
    w      = next_winner(req, last_w);
    last_w = w;
    run_frame(w, cyc_no + 2, 1'b0, 1'b1, 0, nt);
    repeat (5) begin
      cyc();
      check("after_drop_busy", s_busy, 0);
    end

    // Random request patterns separated by random idle gaps.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) cyc();
      req    = 2'($urandom_range(1, 3));
      w      = next_winner(req, last_w);
      last_w = w;
      run_frame(w, cyc_no + 2, 1'b1, 1'b0, 0, nt);
    end

    // Asynchronous reset in the middle of a frame, after byte 3.
    req    = 2'b11;
    w      = next_winner(req, last_w);
    last_w = w;
    run_frame(w, cyc_no + 2, 1'b1, 1'b0, 4, nt);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_trigger", drv_trigger, 0);
    check("async_data", drv_data, 0);
    check("async_busy", busy, 0);
    check("async_adv", src_advance, 0);
    check("async_index", {led_index, rgb_index}, 0);
    @(posedge CLK);
    #1;
    repeat (2) cyc();
    rst_n  = 1'b1;
    last_w = NREQ - 1;
    new_pattern();
    req    = 2'b10;
    w      = next_winner(req, last_w);
    last_w = w;
    run_frame(w, cyc_no + 2, 1'b1, 1'b0, 0, nt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_no);
    $fatal(1, "watchdog expired");
  end

endmodule
